// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: shared memory port handshake between the sequencer and the memory block
//   mem_req  : request, held until mem_ack
//   mem_we   : write strobe, valid while mem_req=1
//   addr_sel : address source, 0=PC, 1=ALU result
//   mem_ack  : one-cycle completion pulse from memory
interface seq_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;
    modport master (output mem_req, mem_we, addr_sel, input mem_ack);
    modport slave (input mem_req, mem_we, addr_sel, output mem_ack);
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the SISC datapath
//   clk, rst_f       : clock, synchronous active-high reset
//   mem              : memory port handshake (seq_ctrl_if.master)
//   opcode, mm, stat : instruction opcode, ALU/branch mask, status flags {C,N,V,Z}
//   ir_load, pc_write, pc_sel, rd_sel, alu_op, stat_en, rf_we, wb_sel : datapath controls
//   halted, err      : sticky HALT / ERR indications
module seq_ctrl #(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [3:0] HALT_OP     = 4'hF
) (
    input  logic             clk,
    input  logic             rst_f,
    seq_ctrl_if.master       mem,
    input  logic [3:0]       opcode,
    input  logic [3:0]       mm,
    input  logic [3:0]       stat,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             rd_sel,
    output logic [1:0]       alu_op,
    output logic             stat_en,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             halted,
    output logic             err
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR} state_t;
    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic       in_mem, is_alu, is_br, is_ls, is_str, legal, taken, timeout, run;
    assign in_mem  = state_q == S_FETCH || state_q == S_MEM;
    assign is_alu  = op_q == 4'h1 || op_q == 4'h2;
    assign is_br   = op_q == 4'h4 || op_q == 4'h5;
    assign is_ls   = op_q == 4'h8 || op_q == 4'h9;
    assign is_str  = op_q == 4'h9;
    assign legal   = opcode inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9};
    assign taken   = mm == 4'h0 || (mm & stat) != 4'h0;
    // a mem_ack on the last allowed cycle takes priority over the timeout
    assign timeout = in_mem && !mem.mem_ack && cnt_q == 8'(MEM_TIMEOUT - 1);
    // reset forces every strobe low so no stray write happens on the reset edge
    assign run     = !rst_f;
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q <= S_FETCH;
            op_q    <= 4'h0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = mem.mem_ack ? S_DECODE : timeout ? S_ERR : S_FETCH;
            S_DECODE: begin
                op_d    = opcode;
                state_d = opcode == HALT_OP ? S_HALT : !legal ? S_ERR :
                          opcode == 4'h0 ? S_FETCH : S_EXEC;
            end
            S_EXEC:   state_d = is_alu ? S_WB : is_ls ? S_MEM : S_FETCH;
            S_MEM:    state_d = mem.mem_ack ? (is_str ? S_FETCH : S_WB) : timeout ? S_ERR : S_MEM;
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
        // staying in FETCH/MEM means no ack this cycle; any state change clears the count
        cnt_d = (in_mem && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
    end
    always_comb begin
        mem.mem_req  = run && in_mem && !mem.mem_ack;
        mem.mem_we   = run && state_q == S_MEM && is_str;
        mem.addr_sel = run && state_q == S_MEM;
        rd_sel       = run && state_q == S_MEM && is_str;
        ir_load      = run && state_q == S_FETCH && mem.mem_ack;
        pc_write     = run && ((state_q == S_FETCH && mem.mem_ack) ||
                               (state_q == S_EXEC && is_br && taken));
        pc_sel       = (run && state_q == S_EXEC && is_br && taken) ?
                       (op_q == 4'h5 ? 2'b10 : 2'b01) : 2'b00;
        // ALU function is held through MEM/WB so the address/result stays stable
        alu_op       = (run && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                        (is_alu || is_ls)) ?
                       (op_q == 4'h1 ? 2'b00 : op_q == 4'h2 ? 2'b01 : 2'b10) : 2'b11;
        stat_en      = run && state_q == S_EXEC && is_alu;
        rf_we        = run && state_q == S_WB;
        wb_sel       = run && state_q == S_WB && is_alu;
        halted       = run && state_q == S_HALT;
        err          = run && state_q == S_ERR;
    end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed checks of the seq_ctrl sequencer
module tb_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode, mm, stat;
    logic       ir_load, pc_write, rd_sel, stat_en, rf_we, wb_sel, halted, err;
    logic [1:0] pc_sel, alu_op;
    int         n_vec = 0;
    int         n_bad = 0;
    seq_ctrl_if bus ();
    seq_ctrl dut (
        .clk(clk), .rst_f(rst_f), .mem(bus), .opcode(opcode), .mm(mm), .stat(stat),
        .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .rd_sel(rd_sel),
        .alu_op(alu_op), .stat_en(stat_en), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic fetch_op(input logic [3:0] op);
        bus.mem_ack = 1'b1;
        opcode = op;
        #1;
        chk("fetch_ir_load", int'(ir_load), 1);
        chk("fetch_pc_write", int'(pc_write), 1);
        chk("fetch_pc_sel", int'(pc_sel), 0);
        chk("fetch_req_drop", int'(bus.mem_req), 0);
        cyc();
        bus.mem_ack = 1'b0;
        #1;
    endtask
    task automatic do_reset();
        rst_f = 1'b1;
        cyc();
        rst_f = 1'b0;
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end
    initial begin
        rst_f = 1'b1; bus.mem_ack = 1'b0; opcode = 4'h0; mm = 4'h0; stat = 4'h0;
        cyc();
        cyc();
        #1;
        chk("rst_mem_req", int'(bus.mem_req), 0);
        chk("rst_alu_op", int'(alu_op), 3);
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_err", int'(err), 0);
        rst_f = 1'b0;
        #1;
        // 1: ALU reg-imm, ack on second fetch cycle
        chk("t1_req", int'(bus.mem_req), 1);
        chk("t1_addr_sel", int'(bus.addr_sel), 0);
        chk("t1_we", int'(bus.mem_we), 0);
        chk("t1_no_ir_load", int'(ir_load), 0);
        cyc();
        fetch_op(4'h2);
        chk("t1_dec_req", int'(bus.mem_req), 0);
        chk("t1_dec_pcw", int'(pc_write), 0);
        cyc(); #1;
        chk("t1_exec_stat_en", int'(stat_en), 1);
        chk("t1_exec_alu_op", int'(alu_op), 1);
        chk("t1_exec_rf_we", int'(rf_we), 0);
        cyc(); #1;
        chk("t1_wb_rf_we", int'(rf_we), 1);
        chk("t1_wb_sel", int'(wb_sel), 1);
        chk("t1_wb_stat_en", int'(stat_en), 0);
        cyc(); #1;
        chk("t1_back_fetch", int'(bus.mem_req), 1);
        // 1b: ALU reg-reg
        fetch_op(4'h1);
        cyc(); #1;
        chk("t1b_alu_op", int'(alu_op), 0);
        cyc(); cyc(); #1;
        // 2: branches
        fetch_op(4'h4);
        mm = 4'b0001; stat = 4'b0001;
        cyc(); #1;
        chk("t2_brr_taken_pcw", int'(pc_write), 1);
        chk("t2_brr_pc_sel", int'(pc_sel), 1);
        cyc(); #1;
        chk("t2_after_br_fetch", int'(bus.mem_req), 1);
        fetch_op(4'h4);
        stat = 4'b0010;
        cyc(); #1;
        chk("t2_brr_not_taken", int'(pc_write), 0);
        cyc(); #1;
        fetch_op(4'h4);
        mm = 4'h0; stat = 4'h0;
        cyc(); #1;
        chk("t2_mm0_taken", int'(pc_write), 1);
        cyc(); #1;
        fetch_op(4'h5);
        cyc(); #1;
        chk("t2_bra_pcw", int'(pc_write), 1);
        chk("t2_bra_pc_sel", int'(pc_sel), 2);
        cyc(); #1;
        // 3: LOD with 5 wait cycles
        fetch_op(4'h8);
        cyc(); #1;
        chk("t3_exec_alu_op", int'(alu_op), 2);
        cyc(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_mem_req_held", int'(bus.mem_req), 1);
            chk("t3_addr_sel_held", int'(bus.addr_sel), 1);
            chk("t3_lod_we", int'(bus.mem_we), 0);
            cyc(); #1;
        end
        bus.mem_ack = 1'b1;
        #1;
        chk("t3_req_drop", int'(bus.mem_req), 0);
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("t3_wb_rf_we", int'(rf_we), 1);
        chk("t3_wb_sel", int'(wb_sel), 0);
        cyc(); #1;
        // 3b: STR
        fetch_op(4'h9);
        cyc(); cyc(); #1;
        chk("t3_str_we", int'(bus.mem_we), 1);
        chk("t3_str_rd_sel", int'(rd_sel), 1);
        chk("t3_str_addr_sel", int'(bus.addr_sel), 1);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("t3_str_no_rf_we", int'(rf_we), 0);
        chk("t3_str_to_fetch", int'(bus.mem_req), 1);
        chk("t3_str_fetch_addr", int'(bus.addr_sel), 0);
        // 4: fetch timeout, then ack on the last allowed cycle
        for (int i = 0; i < 14; i++) cyc();
        #1;
        chk("t4_cycle15_req", int'(bus.mem_req), 1);
        chk("t4_cycle15_err", int'(err), 0);
        cyc(); #1;
        chk("t4_err", int'(err), 1);
        chk("t4_err_req", int'(bus.mem_req), 0);
        bus.mem_ack = 1'b1;
        #1;
        chk("t4_err_ignores_ack", int'(ir_load), 0);
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("t4_err_sticky", int'(err), 1);
        do_reset();
        chk("t4_rst_clears_err", int'(err), 0);
        for (int i = 0; i < 14; i++) cyc();
        fetch_op(4'h0);
        chk("t4_ack15_no_err", int'(err), 0);
        cyc(); #1;
        chk("t4_nop_to_fetch", int'(bus.mem_req), 1);
        // 5: halt and illegal opcode
        fetch_op(4'hF);
        cyc(); #1;
        chk("t5_halted", int'(halted), 1);
        chk("t5_halt_req", int'(bus.mem_req), 0);
        cyc(); cyc(); #1;
        chk("t5_halt_sticky_req", int'(bus.mem_req), 0);
        chk("t5_halt_sticky", int'(halted), 1);
        do_reset();
        chk("t5_rst_halted", int'(halted), 0);
        fetch_op(4'h3);
        cyc(); #1;
        chk("t5_illegal_err", int'(err), 1);
        do_reset();
        chk("t5_rst_err", int'(err), 0);
        chk("t5_rst_fetch", int'(bus.mem_req), 1);
        // 6: reset during MEM, late ack becomes the fetch ack
        fetch_op(4'h8);
        cyc(); cyc(); #1;
        chk("t6_mem_req", int'(bus.mem_req), 1);
        rst_f = 1'b1;
        #1;
        chk("t6_rst_no_rf_we", int'(rf_we), 0);
        chk("t6_rst_no_pcw", int'(pc_write), 0);
        cyc();
        rst_f = 1'b0;
        #1;
        chk("t6_fetch_req", int'(bus.mem_req), 1);
        chk("t6_fetch_addr", int'(bus.addr_sel), 0);
        chk("t6_no_rf_we", int'(rf_we), 0);
        fetch_op(4'h0);
        chk("t6_decode_no_rf_we", int'(rf_we), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
